// File: rtl/peripheral_axi4_arbiter.sv
// peripheral_axi4_arbiter
// Two-requester front end onto a single AXI4 (AXI3-style write-id) master
// port. One single-beat transfer is in flight at a time. Requesters are
// arbitrated by alternating priority, each transfer is guarded by a
// timeout that completes with SLVERR, and the completion is reported to the
// granted requester as a one-cycle rsp_valid pulse.
//
// Ports:
//   aclk, areset               clock, synchronous active-high reset
//   req_valid/req_ready        per-requester request strobe / accept pulse
//   req_write/addr/wdata/wstrb per-requester request payload (packed by index)
//   rsp_valid/rsp_rdata/resp   per-requester completion pulse and result
//   aw*/w*/b*                  AXI write address, write data, write response
//   ar*/r*                     AXI read address, read data
module peripheral_axi4_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic        awvalid,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t      state_r;
  logic        grant_r;
  logic        last_grant_r;
  logic [15:0] tmo_cnt_r;

  logic        grant_s;
  logic        adv_s;
  logic        active_s;
  logic        timeout_hit_s;
  logic [1:0]  rsp_onehot_s;
  logic        unused_s;

  // Alternating priority: a lone requester wins, a tie goes to the one not served last.
  function automatic logic pick_grant(input logic [1:0] valid, input logic last);
    logic g;
    case (valid)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      2'b11:   g = ~last;
      default: g = 1'b0;
    endcase
    return g;
  endfunction

  // Fixed single-beat burst attributes.
  assign awlen   = 4'd0;
  assign awsize  = 3'd2;
  assign awburst = 2'd1;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;
  assign arlen   = 4'd0;
  assign arsize  = 3'd2;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  // Response ids and rlast carry no information for a single outstanding beat.
  assign unused_s = ^{bid, rid, rlast};

  assign rsp_onehot_s  = grant_r ? 2'b10 : 2'b01;
  // Counter is cleared on entry, so expiry fires on the TIMEOUT-th active cycle.
  assign timeout_hit_s = (tmo_cnt_r >= 16'(TIMEOUT - 32'd1));

  // Grant selection and combinational accept pulse while idle.
  always_comb begin
    grant_s   = pick_grant(req_valid, last_grant_r);
    req_ready = 2'b00;
    if (!areset && (state_r == ST_IDLE) && (|req_valid)) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Per-state progress condition; a pending valid that is not yet accepted blocks WADDR.
  always_comb begin
    adv_s    = 1'b0;
    active_s = 1'b0;
    case (state_r)
      ST_WADDR: begin
        active_s = 1'b1;
        adv_s    = (!awvalid || awready) && (!wvalid || wready);
      end
      ST_WRESP: begin
        active_s = 1'b1;
        adv_s    = bvalid;
      end
      ST_RADDR: begin
        active_s = 1'b1;
        adv_s    = arready;
      end
      ST_RDATA: begin
        active_s = 1'b1;
        adv_s    = rvalid;
      end
      default: begin
        active_s = 1'b0;
        adv_s    = 1'b0;
      end
    endcase
  end

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      tmo_cnt_r    <= 16'd0;
      awid         <= 4'd0;
      awadr        <= 32'd0;
      awvalid      <= 1'b0;
      wid          <= 4'd0;
      wrdata       <= 32'd0;
      wstrb        <= 4'd0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      arid         <= 4'd0;
      araddr       <= 32'd0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= 32'd0;
      rsp_resp     <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_r      <= grant_s;
            last_grant_r <= grant_s;
            tmo_cnt_r    <= 16'd0;
            if (req_write[grant_s]) begin
              state_r <= ST_WADDR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awid    <= {3'b000, grant_s};
              wid     <= {3'b000, grant_s};
              awadr   <= grant_s ? req_addr[63:32]  : req_addr[31:0];
              wrdata  <= grant_s ? req_wdata[63:32] : req_wdata[31:0];
              wstrb   <= grant_s ? req_wstrb[7:4]   : req_wstrb[3:0];
            end else begin
              state_r <= ST_RADDR;
              arvalid <= 1'b1;
              arid    <= {3'b000, grant_s};
              araddr  <= grant_s ? req_addr[63:32] : req_addr[31:0];
            end
          end
        end
        ST_WADDR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (adv_s) begin
            state_r <= ST_WRESP;
            bready  <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (bvalid) begin
            state_r   <= ST_DONE;
            bready    <= 1'b0;
            rsp_valid <= rsp_onehot_s;
            rsp_resp  <= bresp;
            rsp_rdata <= 32'd0;
          end
        end
        ST_RADDR: begin
          if (arready) begin
            state_r <= ST_RDATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (rvalid) begin
            state_r   <= ST_DONE;
            rready    <= 1'b0;
            rsp_valid <= rsp_onehot_s;
            rsp_resp  <= rresp;
            rsp_rdata <= rdata;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 2'b00;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (active_s) tmo_cnt_r <= tmo_cnt_r + 16'd1;

      // Expiry overrides the state logic above unless the slave progressed this cycle.
      if (active_s && !adv_s && timeout_hit_s) begin
        state_r   <= ST_DONE;
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        bready    <= 1'b0;
        arvalid   <= 1'b0;
        rready    <= 1'b0;
        rsp_valid <= rsp_onehot_s;
        rsp_resp  <= 2'b10;
        rsp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: doc/peripheral_axi4_arbiter.md
PERIPHERAL_AXI4_ARBITER -- requirements
Module: peripheral_axi4_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..65535: cycles to wait for slave progress before an error completion.
REQ-002 The block SHALL use one clock, aclk; reset areset SHALL be synchronous and active-high.
REQ-003 aclk  input  1  clock; all state updates on rising edge.
REQ-004 areset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  request strobe; bit i belongs to requester i.
REQ-006 req_ready  output  2  one-cycle accept pulse per requester.
REQ-007 req_write  input  2  1 = write, 0 = read.
REQ-008 req_addr  input  64  byte address; requester i at [32i+31:32i].
REQ-009 req_wdata  input  64  write data; same packing as req_addr.
REQ-010 req_wstrb  input  8  byte strobes; requester i at [4i+3:4i].
REQ-011 rsp_valid  output  2  one-cycle completion pulse to requester i.
REQ-012 rsp_rdata  output  32  read data, qualified by rsp_valid; 0 for writes.
REQ-013 rsp_resp  output  2  AXI response code of the completed transfer.
REQ-014 awid/awadr/awvalid  output  4/32/1  write address to slave; awready  input  1.
REQ-015 awlen/awsize/awburst/awlock/awcache/awprot  output  4/3/2/2/4/3  constants 0/2/1/0/0/0.
REQ-016 wid/wrdata/wstrb/wlast/wvalid  output  4/32/4/1/1  write data; wready  input  1.
REQ-017 bid/bresp/bvalid  input  4/2/1  write response; bready  output  1.
REQ-018 arid/araddr/arvalid  output  4/32/1; arready  input  1; arlen/arsize/arlock/arcache/arprot  output  constants 0/2/0/0/0.
REQ-019 rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1; rready  output  1.

Function
REQ-020 FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
REQ-021 IDLE, any req_valid set: grant one requester g, pulse req_ready[g] that cycle, capture its write/addr/wdata/wstrb into holding registers; next WADDR if write, else RADDR.
REQ-022 Arbitration: a lone requester wins; both valid: the requester not granted last wins; last_grant updates on every grant.
REQ-023 req_ready SHALL be 0 outside IDLE; a req_valid deasserted before grant is dropped without trace.
REQ-024 WADDR: awvalid and wvalid asserted together from state entry; awadr/wrdata/wstrb from holding registers; wlast=1; awid=wid={3'b0,g}; each valid deasserts independently after its valid&ready edge; both handshakes done -> WRESP.
REQ-025 WRESP: bready=1; bvalid captures bresp -> DONE; bid ignored.
REQ-026 RADDR: arvalid=1, araddr from holding register, arid={3'b0,g}; arvalid&arready -> RDATA.
REQ-027 RDATA: rready=1; rvalid captures rdata and rresp -> DONE; rid and rlast ignored.
REQ-028 AXI outputs registered; awadr/wrdata/wstrb/araddr stable while the matching valid is high.
REQ-029 Timeout counter: cleared on entry to WADDR/RADDR, increments each cycle in WADDR/WRESP/RADDR/RDATA; on reaching TIMEOUT, drop all AXI valids/readies, go DONE with rsp_resp=2'b10 (SLVERR), rsp_rdata=0.
REQ-030 Slave completion in the same cycle as timeout expiry: completion wins; captured response is reported.
REQ-031 DONE: rsp_valid[g]=1 for exactly one cycle with rsp_rdata/rsp_resp; next IDLE; the earliest next grant is the cycle after DONE.
REQ-032 Latency with zero-wait slave: rsp_valid exactly 3 cycles after the req_ready pulse, for reads and writes.

Reset
REQ-033 areset: state IDLE; awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid, rsp_rdata, rsp_resp, timeout counter all 0; other AXI outputs 0 except constants; last_grant=1 so requester 0 wins the first tie.
REQ-034 Reset mid-transaction SHALL abandon it with no rsp_valid; reset values are reached at the reset edge.

Verification
REQ-035 Requester 0 writes addr 0x10, 0xDEADBEEF, wstrb 4'hF -> awadr 0x10, wrdata 0xDEADBEEF, awid 0; bresp OKAY -> rsp_valid=2'b01, rsp_resp=0.
REQ-036 Requester 1 reads 0x10 -> arid 1, araddr 0x10; rsp_valid=2'b10, rsp_rdata 0xDEADBEEF, rsp_resp 0.
REQ-037 Both req_valid held high for 4 transfers -> grant order 0,1,0,1, one req_ready pulse each.
REQ-038 awready low 3 cycles, wready high -> wvalid drops after 1 cycle, awvalid held 4 cycles, then single WRESP phase.
REQ-039 TIMEOUT=8, slave never asserts rvalid -> rsp_resp 2'b10 and rsp_rdata 0 on timeout expiry; FSM returns to IDLE; the next request completes normally.
REQ-040 areset in WRESP -> no rsp_valid; all valids 0 at that edge; requester 0 wins the first tie afterwards.
